// File: rtl/ulpb_tx_sequencer_if.sv
// ulpb_tx_sequencer_if
//   Word handshake bundle between the TX sequencer (master) and the
//   ulpb_node32 TX port (slave).
//   master drives : TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK
//   slave drives  : TX_ACK, TX_FAIL, TX_SUCC
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

interface ulpb_tx_sequencer_if;
  logic [`ADDR_WIDTH-1:0] TX_ADDR;
  logic [`DATA_WIDTH-1:0] TX_DATA;
  logic                   TX_PEND;
  logic                   TX_REQ;
  logic                   PRIORITY;
  logic                   TX_RESP_ACK;
  logic                   TX_ACK;
  logic                   TX_FAIL;
  logic                   TX_SUCC;

  modport master (
    output TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK,
    input  TX_ACK, TX_FAIL, TX_SUCC
  );

  modport slave (
    input  TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK,
    output TX_ACK, TX_FAIL, TX_SUCC
  );
endinterface

// File: rtl/ulpb_tx_sequencer.sv
// ulpb_tx_sequencer
//   Buffers a burst of data words and plays them out over the ulpb_node32
//   TX word handshake (TX_REQ/TX_ACK with TX_PEND chaining), then collects
//   TX_SUCC/TX_FAIL and answers with TX_RESP_ACK.
//   CLK_EXT, RESETn  : clock, synchronous active-low reset
//   WR_EN, WR_DATA   : push a word (only while idle and not full)
//   FULL, COUNT      : buffer status
//   START, ADDR, PRIO: launch a burst; ADDR/PRIO latched on accepted START
//   BUSY, DONE, ERR  : burst in progress, success pulse, failure pulse
//   tx               : node-side handshake (master modport)
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module ulpb_tx_sequencer #(
  parameter int DEPTH       = 8,
  parameter int DEPTH_LOG2  = 3,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                   CLK_EXT,
  input  logic                   RESETn,
  input  logic                   WR_EN,
  input  logic [`DATA_WIDTH-1:0] WR_DATA,
  output logic                   FULL,
  output logic [DEPTH_LOG2:0]    COUNT,
  input  logic                   START,
  input  logic [`ADDR_WIDTH-1:0] ADDR,
  input  logic                   PRIO,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  ulpb_tx_sequencer_if.master    tx
);

  localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DEPTH_LOG2:0]  CNT_ZERO   = '0;
  localparam logic [DEPTH_LOG2:0]  CNT_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]  CNT_FULL   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_ACK_LOW  = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [`DATA_WIDTH-1:0]  mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_r, rd_ptr_r;
  logic [DEPTH_LOG2:0]     count_r, count_s, count_push_s;
  logic                    full_r, full_s;
  logic [TIMER_W-1:0]      timer_r, timer_s;
  logic                    fail_r, fail_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    err_r, err_s;
  logic [`ADDR_WIDTH-1:0]  tx_addr_r, tx_addr_s;
  logic [`DATA_WIDTH-1:0]  tx_data_r, tx_data_s;
  logic                    tx_pend_r, tx_pend_s;
  logic                    tx_req_r, tx_req_s;
  logic                    priority_r, priority_s;
  logic                    resp_ack_r, resp_ack_s;
  logic                    push_s, pop_s, flush_s;
  logic [`DATA_WIDTH-1:0]  head_s;

  assign head_s = mem_r[rd_ptr_r];

  // Next-state, buffer control and next-output decode
  always_comb begin
    state_s    = state_r;
    push_s     = WR_EN && !busy_r && !full_r;
    pop_s      = 1'b0;
    flush_s    = 1'b0;
    timer_s    = '0;
    fail_s     = fail_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    tx_addr_s  = tx_addr_r;
    tx_data_s  = tx_data_r;
    tx_pend_s  = tx_pend_r;
    tx_req_s   = tx_req_r;
    priority_s = priority_r;
    resp_ack_s = resp_ack_r;
    // A write in the START cycle still lands, so the first TX_PEND must see it.
    count_push_s = count_r + (DEPTH_LOG2+1)'(push_s);

    case (state_r)
      ST_IDLE: begin
        if (START && (count_r != CNT_ZERO)) begin
          state_s    = ST_REQ;
          busy_s     = 1'b1;
          fail_s     = 1'b0;
          tx_addr_s  = ADDR;
          tx_req_s   = 1'b1;
          tx_data_s  = head_s;
          tx_pend_s  = (count_push_s > CNT_ONE);
          priority_s = PRIO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Node abort outranks both a same-cycle ACK and the timeout.
        if (tx.TX_FAIL) begin
          tx_req_s   = 1'b0;
          priority_s = 1'b0;
          fail_s     = 1'b1;
          resp_ack_s = 1'b1;
          state_s    = ST_RESP;
        end else if (tx.TX_ACK) begin
          pop_s      = 1'b1;
          tx_req_s   = 1'b0;
          priority_s = 1'b0;
          state_s    = ST_ACK_LOW;
        end else if ((ACK_TIMEOUT != 0) && (timer_r == TIMER_LAST)) begin
          tx_req_s   = 1'b0;
          priority_s = 1'b0;
          flush_s    = 1'b1;
          err_s      = 1'b1;
          busy_s     = 1'b0;
          state_s    = ST_IDLE;
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
      end
      ST_ACK_LOW: begin
        if (tx.TX_FAIL) begin
          fail_s     = 1'b1;
          resp_ack_s = 1'b1;
          state_s    = ST_RESP;
        end else if (!tx.TX_ACK) begin
          if (count_r != CNT_ZERO) begin
            tx_req_s   = 1'b1;
            tx_data_s  = head_s;
            tx_pend_s  = (count_r > CNT_ONE);
            priority_s = 1'b0;
            state_s    = ST_REQ;
          end else begin
            state_s = ST_WAIT_RES;
          end
        end else begin
          state_s = ST_ACK_LOW;
        end
      end
      ST_WAIT_RES: begin
        // SUCC together with FAIL counts as a failure.
        if (tx.TX_SUCC || tx.TX_FAIL) begin
          fail_s     = tx.TX_FAIL;
          resp_ack_s = 1'b1;
          state_s    = ST_RESP;
        end else begin
          state_s = ST_WAIT_RES;
        end
      end
      ST_RESP: begin
        if (!tx.TX_SUCC && !tx.TX_FAIL) begin
          resp_ack_s = 1'b0;
          flush_s    = 1'b1;
          done_s     = !fail_r;
          err_s      = fail_r;
          busy_s     = 1'b0;
          state_s    = ST_IDLE;
        end else begin
          fail_s     = fail_r | tx.TX_FAIL;
          resp_ack_s = 1'b1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        tx_req_s   = 1'b0;
        priority_s = 1'b0;
        resp_ack_s = 1'b0;
        busy_s     = 1'b0;
        flush_s    = 1'b1;
      end
    endcase

    if (flush_s) begin
      count_s = CNT_ZERO;
    end else if (push_s) begin
      count_s = count_r + CNT_ONE;
    end else if (pop_s) begin
      count_s = count_r - CNT_ONE;
    end else begin
      count_s = count_r;
    end
    full_s = (count_s == CNT_FULL);
  end

  // Burst word storage; occupancy lives in the pointers and count, so no reset
  always_ff @(posedge CLK_EXT) begin
    if (RESETn && push_s) begin
      mem_r[wr_ptr_r] <= WR_DATA;
    end
  end

  // State, pointer and registered-output update with synchronous reset
  always_ff @(posedge CLK_EXT) begin
    if (!RESETn) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      timer_r    <= '0;
      fail_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      tx_addr_r  <= '0;
      tx_data_r  <= '0;
      tx_pend_r  <= 1'b0;
      tx_req_r   <= 1'b0;
      priority_r <= 1'b0;
      resp_ack_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      wr_ptr_r   <= flush_s ? '0 : (push_s ? wr_ptr_r + DEPTH_LOG2'(1) : wr_ptr_r);
      rd_ptr_r   <= flush_s ? '0 : (pop_s  ? rd_ptr_r + DEPTH_LOG2'(1) : rd_ptr_r);
      count_r    <= count_s;
      full_r     <= full_s;
      timer_r    <= timer_s;
      fail_r     <= fail_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      tx_addr_r  <= tx_addr_s;
      tx_data_r  <= tx_data_s;
      tx_pend_r  <= tx_pend_s;
      tx_req_r   <= tx_req_s;
      priority_r <= priority_s;
      resp_ack_r <= resp_ack_s;
    end
  end

  assign FULL           = full_r;
  assign COUNT          = count_r;
  assign BUSY           = busy_r;
  assign DONE           = done_r;
  assign ERR            = err_r;
  assign tx.TX_ADDR     = tx_addr_r;
  assign tx.TX_DATA     = tx_data_r;
  assign tx.TX_PEND     = tx_pend_r;
  assign tx.TX_REQ      = tx_req_r;
  assign tx.PRIORITY    = priority_r;
  assign tx.TX_RESP_ACK = resp_ack_r;

endmodule

// File: tb/tb_ulpb_tx_sequencer.sv
// tb_ulpb_tx_sequencer
//   Self-checking bench: words written are pushed to a scoreboard queue and
//   popped when the sequencer presents them on TX_DATA; the bench plays the
//   node side of the handshake.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module tb_ulpb_tx_sequencer;
  localparam int DW    = `DATA_WIDTH;
  localparam int AW    = `ADDR_WIDTH;
  localparam int DEPTH = 8;
  localparam int DL2   = 3;
  localparam int TMO   = 16;

  logic          CLK_EXT = 1'b0;
  logic          RESETn, WR_EN, START, PRIO;
  logic [DW-1:0] WR_DATA;
  logic [AW-1:0] ADDR;
  logic          FULL, BUSY, DONE, ERR;
  logic [DL2:0]  COUNT;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  bit model_busy = 1'b0;

  ulpb_tx_sequencer_if tx_if();

  always #5 CLK_EXT = ~CLK_EXT;

  ulpb_tx_sequencer #(.DEPTH(DEPTH), .DEPTH_LOG2(DL2), .ACK_TIMEOUT(TMO)) dut (
    .CLK_EXT(CLK_EXT), .RESETn(RESETn), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .FULL(FULL), .COUNT(COUNT), .START(START), .ADDR(ADDR), .PRIO(PRIO),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .tx(tx_if)
  );

  task automatic cyc();
    @(negedge CLK_EXT);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    WR_EN = 1'b1; WR_DATA = d; cyc(); WR_EN = 1'b0;
    if (!model_busy && exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  task automatic launch(input logic [AW-1:0] a, input logic p);
    START = 1'b1; ADDR = a; PRIO = p; cyc(); START = 1'b0;
    model_busy = (exp_q.size() != 0);
  endtask

  task automatic test_reset();
    RESETn = 1'b0; WR_EN = 1'b0; START = 1'b0; PRIO = 1'b0; ADDR = '0; WR_DATA = '0;
    tx_if.TX_ACK = 1'b0; tx_if.TX_FAIL = 1'b0; tx_if.TX_SUCC = 1'b0;
    cyc(); cyc();
    checks++; if ({BUSY, DONE, ERR, FULL} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {BUSY, DONE, ERR, FULL}); end
    checks++; if (COUNT !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    checks++; if ({tx_if.TX_REQ, tx_if.TX_RESP_ACK, tx_if.TX_PEND, tx_if.PRIORITY} !== 4'b0000) begin errors++; $display("FAIL reset_tx: got %b want 0000", {tx_if.TX_REQ, tx_if.TX_RESP_ACK, tx_if.TX_PEND, tx_if.PRIORITY}); end
    RESETn = 1'b1; cyc();
  endtask

  task automatic test_burst();
    logic [DW-1:0] exp_w;
    int budget;
    bit first;
    push_word(32'hA000_000A); push_word(32'hB000_000B); push_word(32'hC000_000C);
    checks++; if (COUNT !== 4'd3) begin errors++; $display("FAIL burst_count: got %0d want 3", COUNT); end
    launch(8'h01, 1'b1);
    checks++; if ({tx_if.TX_REQ, BUSY} !== 2'b11) begin errors++; $display("FAIL burst_start: got req/busy %b want 11", {tx_if.TX_REQ, BUSY}); end
    checks++; if (tx_if.TX_ADDR !== 8'h01) begin errors++; $display("FAIL burst_addr: got %h want 01", tx_if.TX_ADDR); end
    first = 1'b1;
    while (exp_q.size() != 0) begin
      budget = 0;
      while (tx_if.TX_REQ !== 1'b1 && budget < 10) begin cyc(); budget++; end
      checks++; if (budget != 0) begin errors++; $display("FAIL burst_req_latency: got %0d extra cycles want 0", budget); end
      if (tx_if.TX_REQ !== 1'b1) break;
      exp_w = exp_q.pop_front();
      checks++; if (tx_if.TX_DATA !== exp_w) begin errors++; $display("FAIL burst_data: got %h want %h", tx_if.TX_DATA, exp_w); end
      checks++; if (tx_if.TX_PEND !== (exp_q.size() != 0)) begin errors++; $display("FAIL burst_pend: got %b want %b", tx_if.TX_PEND, exp_q.size() != 0); end
      checks++; if (tx_if.PRIORITY !== first) begin errors++; $display("FAIL burst_prio: got %b want %b", tx_if.PRIORITY, first); end
      first = 1'b0;
      tx_if.TX_ACK = 1'b1; cyc();
      checks++; if (tx_if.TX_REQ !== 1'b0) begin errors++; $display("FAIL burst_req_drop: got %b want 0", tx_if.TX_REQ); end
      tx_if.TX_ACK = 1'b0; cyc();
    end
    tx_if.TX_SUCC = 1'b1; cyc();
    checks++; if ({tx_if.TX_RESP_ACK, DONE} !== 2'b10) begin errors++; $display("FAIL burst_resp_ack: got ack/done %b want 10", {tx_if.TX_RESP_ACK, DONE}); end
    cyc();
    checks++; if (tx_if.TX_RESP_ACK !== 1'b1) begin errors++; $display("FAIL burst_resp_hold: got %b want 1", tx_if.TX_RESP_ACK); end
    tx_if.TX_SUCC = 1'b0; cyc();
    checks++; if ({DONE, ERR, BUSY, tx_if.TX_RESP_ACK} !== 4'b1000) begin errors++; $display("FAIL burst_done: got done/err/busy/ack %b want 1000", {DONE, ERR, BUSY, tx_if.TX_RESP_ACK}); end
    checks++; if (COUNT !== 4'd0) begin errors++; $display("FAIL burst_count_end: got %0d want 0", COUNT); end
    cyc();
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL burst_done_pulse: got %b want 0", DONE); end
    model_busy = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) push_word(32'hF000_0000 + DW'(i));
    checks++; if ({FULL, COUNT} !== {1'b1, 4'd8}) begin errors++; $display("FAIL fill_full: got full=%b count=%0d want full=1 count=8", FULL, COUNT); end
    launch(8'h22, 1'b0);
    push_word(32'hDEAD_BEEF);
    checks++; if ({BUSY, COUNT} !== {1'b1, 4'd8}) begin errors++; $display("FAIL fill_busy_write: got busy=%b count=%0d want busy=1 count=8", BUSY, COUNT); end
    checks++; if ({tx_if.TX_DATA, tx_if.TX_PEND, tx_if.PRIORITY} !== {exp_q[0], 1'b1, 1'b0}) begin errors++; $display("FAIL fill_head: got %h pend=%b prio=%b want %h pend=1 prio=0", tx_if.TX_DATA, tx_if.TX_PEND, tx_if.PRIORITY, exp_q[0]); end
    tx_if.TX_FAIL = 1'b1; cyc(); tx_if.TX_FAIL = 1'b0; cyc();
    checks++; if ({ERR, FULL, COUNT} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL fill_abort: got err=%b full=%b count=%0d want 1 0 0", ERR, FULL, COUNT); end
    exp_q.delete(); model_busy = 1'b0; cyc();
  endtask

  task automatic test_fail_mid();
    logic [DW-1:0] exp_w;
    int budget;
    for (int i = 0; i < 4; i++) push_word(32'h3300_0000 + DW'(i));
    launch(8'h05, 1'b0);
    for (int w = 0; w < 2; w++) begin
      budget = 0;
      while (tx_if.TX_REQ !== 1'b1 && budget < 10) begin cyc(); budget++; end
      exp_w = exp_q.pop_front();
      checks++; if ({tx_if.TX_REQ, tx_if.TX_DATA, tx_if.TX_PEND} !== {1'b1, exp_w, 1'b1}) begin errors++; $display("FAIL failmid_word: got req=%b %h pend=%b want req=1 %h pend=1", tx_if.TX_REQ, tx_if.TX_DATA, tx_if.TX_PEND, exp_w); end
      tx_if.TX_ACK = 1'b1; cyc(); tx_if.TX_ACK = 1'b0; cyc();
    end
    checks++; if ({tx_if.TX_REQ, tx_if.TX_DATA} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL failmid_word3: got req=%b %h want req=1 %h", tx_if.TX_REQ, tx_if.TX_DATA, exp_q[0]); end
    tx_if.TX_FAIL = 1'b1; cyc();
    checks++; if ({tx_if.TX_REQ, tx_if.TX_RESP_ACK} !== 2'b01) begin errors++; $display("FAIL failmid_abort: got req/ack %b want 01", {tx_if.TX_REQ, tx_if.TX_RESP_ACK}); end
    cyc(); cyc();
    checks++; if ({tx_if.TX_RESP_ACK, ERR} !== 2'b10) begin errors++; $display("FAIL failmid_hold: got ack/err %b want 10", {tx_if.TX_RESP_ACK, ERR}); end
    tx_if.TX_FAIL = 1'b0; cyc();
    checks++; if ({ERR, DONE, BUSY, tx_if.TX_RESP_ACK, COUNT} !== {4'b1000, 4'd0}) begin errors++; $display("FAIL failmid_err: got err/done/busy/ack %b count=%0d want 1000 count=0", {ERR, DONE, BUSY, tx_if.TX_RESP_ACK}, COUNT); end
    cyc();
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL failmid_err_pulse: got %b want 0", ERR); end
    exp_q.delete(); model_busy = 1'b0;
  endtask

  task automatic test_timeout();
    int hi;
    int budget;
    push_word(32'h7000_0001); push_word(32'h7000_0002);
    launch(8'h10, 1'b1);
    hi = 0; budget = 0;
    while (tx_if.TX_REQ === 1'b1 && budget < 40) begin hi++; cyc(); budget++; end
    checks++; if (hi != TMO) begin errors++; $display("FAIL timeout_len: got %0d cycles want %0d", hi, TMO); end
    checks++; if ({ERR, BUSY, DONE, COUNT} !== {3'b100, 4'd0}) begin errors++; $display("FAIL timeout_err: got err/busy/done %b count=%0d want 100 count=0", {ERR, BUSY, DONE}, COUNT); end
    cyc();
    checks++; if ({ERR, tx_if.TX_REQ} !== 2'b00) begin errors++; $display("FAIL timeout_idle: got err/req %b want 00", {ERR, tx_if.TX_REQ}); end
    exp_q.delete(); model_busy = 1'b0;
  endtask

  task automatic test_empty_and_reset();
    launch(8'h33, 1'b1);
    checks++; if ({BUSY, tx_if.TX_REQ} !== 2'b00) begin errors++; $display("FAIL empty_start: got busy/req %b want 00", {BUSY, tx_if.TX_REQ}); end
    cyc(); cyc();
    checks++; if ({BUSY, tx_if.TX_REQ, DONE, ERR} !== 4'b0000) begin errors++; $display("FAIL empty_quiet: got %b want 0000", {BUSY, tx_if.TX_REQ, DONE, ERR}); end
    push_word(32'h5500_0001); push_word(32'h5500_0002);
    launch(8'h34, 1'b1);
    checks++; if ({tx_if.TX_REQ, tx_if.PRIORITY} !== 2'b11) begin errors++; $display("FAIL rst_pre: got req/prio %b want 11", {tx_if.TX_REQ, tx_if.PRIORITY}); end
    RESETn = 1'b0; cyc();
    checks++; if ({tx_if.TX_REQ, tx_if.TX_RESP_ACK, BUSY, DONE, ERR, FULL, tx_if.TX_PEND, tx_if.PRIORITY} !== 8'h00) begin errors++; $display("FAIL rst_mid_flags: got %b want 00000000", {tx_if.TX_REQ, tx_if.TX_RESP_ACK, BUSY, DONE, ERR, FULL, tx_if.TX_PEND, tx_if.PRIORITY}); end
    checks++; if ({COUNT, tx_if.TX_DATA, tx_if.TX_ADDR} !== '0) begin errors++; $display("FAIL rst_mid_values: got count=%0d data=%h addr=%h want 0", COUNT, tx_if.TX_DATA, tx_if.TX_ADDR); end
    RESETn = 1'b1; cyc(); cyc();
    checks++; if ({tx_if.TX_REQ, BUSY, DONE, ERR} !== 4'b0000) begin errors++; $display("FAIL rst_after: got %b want 0000", {tx_if.TX_REQ, BUSY, DONE, ERR}); end
    exp_q.delete(); model_busy = 1'b0;
  endtask

  task automatic test_ack_fail_same();
    push_word(32'h6600_0001); push_word(32'h6600_0002);
    launch(8'h44, 1'b1);
    checks++; if ({tx_if.TX_REQ, tx_if.TX_DATA} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL ackfail_word1: got req=%b %h want req=1 %h", tx_if.TX_REQ, tx_if.TX_DATA, exp_q[0]); end
    tx_if.TX_ACK = 1'b1; tx_if.TX_FAIL = 1'b1; cyc();
    checks++; if ({tx_if.TX_REQ, tx_if.TX_RESP_ACK, COUNT} !== {2'b01, 4'd2}) begin errors++; $display("FAIL ackfail_resp: got req/ack %b count=%0d want 01 count=2", {tx_if.TX_REQ, tx_if.TX_RESP_ACK}, COUNT); end
    tx_if.TX_ACK = 1'b0; tx_if.TX_FAIL = 1'b0; cyc();
    checks++; if ({ERR, DONE, tx_if.TX_REQ, COUNT} !== {3'b100, 4'd0}) begin errors++; $display("FAIL ackfail_err: got err/done/req %b count=%0d want 100 count=0", {ERR, DONE, tx_if.TX_REQ}, COUNT); end
    cyc();
    checks++; if ({tx_if.TX_REQ, BUSY} !== 2'b00) begin errors++; $display("FAIL ackfail_idle: got req/busy %b want 00", {tx_if.TX_REQ, BUSY}); end
    exp_q.delete(); model_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_burst();
    test_fill();
    test_fail_mid();
    test_timeout();
    test_empty_and_reset();
    test_ack_fail_same();
    test_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
